// File: rtl/taxi_eth_phy_10g_rx_link_ctrl.sv
// taxi_eth_phy_10g_rx_link_ctrl: 10G RX bring-up FSM driving SERDES reset, lock qualification, retry and link statistics.
module taxi_eth_phy_10g_rx_link_ctrl #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cfg_restart,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  input  logic        phy_reset_req,
  output logic        serdes_rx_reset,
  output logic        link_up,
  output logic        link_fail,
  output logic [2:0]  state,
  output logic [3:0]  retry_count,
  output logic [15:0] link_down_count
);
  localparam int TMAX = (LOCK_TIMEOUT > STABLE_CYCLES)
    ? ((LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES)
    : ((STABLE_CYCLES > RESET_CYCLES) ? STABLE_CYCLES : RESET_CYCLES);
  localparam int TW = $clog2(TMAX) + 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0, RESET = 3'd1, WAIT_LOCK = 3'd2, STABLE = 3'd3, UP = 3'd4, FAIL = 3'd5
  } state_t;
  state_t st, st_n;
  logic [TW-1:0] tmr;
  logic [3:0] rc_n;
  logic good, restart, ldc_inc;
  assign good = rx_block_lock & ~rx_high_ber;
  always_comb begin
    st_n = st;
    rc_n = retry_count;
    restart = 1'b0;
    ldc_inc = 1'b0;
    if (!enable) st_n = IDLE;
    else if (cfg_restart && st != IDLE) begin
      st_n = RESET;
      rc_n = '0;
      restart = 1'b1;
    end else case (st)
      IDLE: st_n = RESET;
      RESET: st_n = (tmr == TW'(RESET_CYCLES - 1)) ? WAIT_LOCK : RESET;
      WAIT_LOCK: begin
        if (good) st_n = STABLE;
        else if (phy_reset_req) st_n = RESET;
        else if (tmr == TW'(LOCK_TIMEOUT - 1)) begin
          st_n = (retry_count == 4'(MAX_RETRIES)) ? FAIL : RESET;
          rc_n = (retry_count == 4'(MAX_RETRIES)) ? retry_count : retry_count + 4'd1;
        end
      end
      STABLE: begin
        if (!good) st_n = WAIT_LOCK;
        else if (tmr == TW'(STABLE_CYCLES - 1)) begin
          st_n = UP;
          rc_n = '0;
        end
      end
      // lock loss wins over a simultaneous PHY reset request
      UP: begin
        st_n = !good ? WAIT_LOCK : phy_reset_req ? RESET : UP;
        ldc_inc = !good | phy_reset_req;
      end
      FAIL: st_n = FAIL;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      tmr <= '0;
      retry_count <= '0;
      link_down_count <= '0;
    end else begin
      st <= st_n;
      tmr <= (st_n != st || restart) ? '0 : (&tmr) ? tmr : tmr + TW'(1);
      retry_count <= rc_n;
      if (ldc_inc && link_down_count != 16'hFFFF) link_down_count <= link_down_count + 16'd1;
    end
  end
  assign state = st;
  assign serdes_rx_reset = (st == IDLE) || (st == RESET);
  assign link_up = (st == UP);
  assign link_fail = (st == FAIL);
endmodule
